// File: rtl/icache_direct_if.sv
// Purpose : CPU-fetch and instruction-memory signal bundle for icache_direct.
// Latency : none, wires only.
// Backpressure: busywait stalls the CPU; mem_busywait stalls the cache's block fetch.
// Ports   : read/pc/instruction/busywait (CPU side), mem_read/mem_address/mem_readdata/mem_busywait (memory side).
// Modports: slave = the cache, master = the environment (CPU fetch stage + instruction memory).
interface icache_direct_if;
  logic         read;
  logic [9:0]   pc;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  modport slave (
    input  read, pc, mem_readdata, mem_busywait,
    output instruction, busywait, mem_read, mem_address
  );

  modport master (
    output read, pc, mem_readdata, mem_busywait,
    input  instruction, busywait, mem_read, mem_address
  );
endinterface

// File: rtl/icache_direct.sv
// Purpose : direct-mapped read-only instruction cache, 16-byte lines, 6-bit block address space.
// Latency : hit 0 stall cycles; miss stalls for detect + MEM_READ cycles + 1 UPDATE cycle, then retries.
// Backpressure: busywait holds the CPU on a miss; MEM_READ waits for mem_busywait to fall.
// Ports   : clock, reset (async active-low), bus (icache_direct_if.slave),
//           hit_count/miss_count only when ICACHE_STATS_EN is defined.
// Option  : ICACHE_STATS_EN adds saturating 16-bit hit and miss counters.
module icache_direct #(
  parameter int NUM_BLOCKS = 8,
  parameter int HIT_DELAY  = 1
) (
  input  logic           clock,
  input  logic           reset,
  icache_direct_if.slave bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]    hit_count,
  output logic [15:0]    miss_count
`endif
);
  localparam int INDEX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W   = 6 - INDEX_W;

  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_e;

  state_e                state_q, state_d;
  logic [5:0]            miss_addr_q, miss_addr_d;
  logic [NUM_BLOCKS-1:0] valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [127:0]          data_q [NUM_BLOCKS];

  logic [INDEX_W-1:0]    pc_idx, fill_idx;
  logic [TAG_W-1:0]      pc_tag, fill_tag;
  logic [1:0]            pc_word;
  logic                  hit;
  logic                  install;
  logic                  unused_bits;

  // HIT_DELAY only shapes simulation timing in the original model; the byte
  // offset is irrelevant for word fetches.
  assign unused_bits = ^{bus.pc[1:0], HIT_DELAY};

  assign pc_word  = bus.pc[3:2];
  assign pc_idx   = bus.pc[3+INDEX_W:4];
  assign pc_tag   = bus.pc[9:4+INDEX_W];
  assign fill_idx = miss_addr_q[INDEX_W-1:0];
  assign fill_tag = miss_addr_q[5:INDEX_W];

  assign hit             = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  assign bus.instruction = hit ? data_q[pc_idx][{pc_word, 5'b0} +: 32] : 32'h0;

  always_comb begin
    state_d         = state_q;
    miss_addr_d     = miss_addr_q;
    install         = 1'b0;
    bus.mem_read    = 1'b0;
    bus.busywait    = 1'b0;
    // Holds the latched miss block, which is 0 out of reset and stays valid
    // through UPDATE so a level-sensitive memory keeps readdata stable.
    bus.mem_address = miss_addr_q;
    unique case (state_q)
      IDLE: begin
        // State is forced to IDLE while reset is low; gating with reset keeps
        // the CPU stall low during reset even if a miss is presented.
        bus.busywait = reset && bus.read && !hit;
        if (bus.read && !hit) begin
          miss_addr_d = bus.pc[9:4];
          state_d     = MEM_READ;
        end
      end
      MEM_READ: begin
        bus.mem_read = 1'b1;
        bus.busywait = 1'b1;
        // MEM_READ is always entered on a clock edge, so the first possible
        // exit edge is a full cycle later, past the combinational rise of
        // mem_busywait in response to mem_read.
        if (!bus.mem_busywait) state_d = UPDATE;
      end
      UPDATE: begin
        bus.busywait = 1'b1;
        install      = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      miss_addr_q <= 6'd0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      if (install) valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid_q alone decides a hit.
  always_ff @(posedge clock) begin
    if (install) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.mem_readdata;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_cnt_q  <= 16'd0;
      miss_cnt_q <= 16'd0;
    end else begin
      if (state_q == IDLE && bus.read && hit && hit_cnt_q != 16'hFFFF)
        hit_cnt_q <= hit_cnt_q + 16'd1;
      if (state_q == IDLE && state_d == MEM_READ && miss_cnt_q != 16'hFFFF)
        miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif
endmodule

// File: tb/tb_icache_direct.sv
// Purpose : directed bench for icache_direct with a line-occupancy model and a per-cycle compare process.
// Latency : the memory model holds mem_busywait high for LAT cycles of mem_read.
// Backpressure: fetches wait out the expected stall cycle by cycle.
module tb_icache_direct;
  localparam int NB  = 8;
  localparam int LAT = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   mem_cnt  = 0;

  logic [7:0] mem [1024];
  bit         model_valid [NB];
  int         model_tag   [NB];

  icache_direct_if bus();

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  icache_direct #(.NUM_BLOCKS(NB), .HIT_DELAY(1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clock = ~clock;

  // Instruction memory: busy for LAT cycles after mem_read rises, block always on readdata.
  always @(posedge clock) mem_cnt <= bus.mem_read ? mem_cnt + 1 : 0;
  assign bus.mem_busywait = bus.mem_read && (mem_cnt < LAT);
  always_comb begin
    bus.mem_readdata = '0;
    for (int k = 0; k < 16; k++)
      bus.mem_readdata[8*k +: 8] = mem[{bus.mem_address, 4'(k)}];
  end

  function automatic logic [31:0] word_at(input int a);
    int b;
    b = a & ~3;
    return {mem[b+3], mem[b+2], mem[b+1], mem[b]};
  endfunction

  function automatic bit model_hit(input int a);
    int blk;
    blk = a / 16;
    return model_valid[blk % NB] && (model_tag[blk % NB] == blk / NB);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every cycle: reset quiets the outputs; with read high the model decides hit or stall.
  always @(negedge clock) begin
    if (!reset) begin
      chk("rst_busywait", 32'(bus.busywait), 32'd0);
      chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
    end else if (bus.read) begin
      if (model_hit(int'(bus.pc))) begin
        chk("hit_busywait", 32'(bus.busywait), 32'd0);
        chk("hit_mem_read", 32'(bus.mem_read), 32'd0);
        chk("hit_instruction", bus.instruction, word_at(int'(bus.pc)));
      end else begin
        chk("miss_busywait", 32'(bus.busywait), 32'd1);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the serving cycle.
  task automatic fetch(input logic [9:0] a, input bit exp_miss,
                       input logic [31:0] exp_instr, input logic [5:0] exp_blk);
    bus.pc   = a;
    bus.read = 1'b1;
    @(negedge clock);
    chk($sformatf("stall_at_%h", a), 32'(bus.busywait), 32'(exp_miss));
    if (!model_hit(int'(a))) begin
      chk("detect_mem_read", 32'(bus.mem_read), 32'd0);
      @(posedge clock);
      for (int k = 0; k <= LAT; k++) begin
        @(negedge clock);
        chk("fill_mem_read", 32'(bus.mem_read), 32'd1);
        chk($sformatf("fill_mem_address_%h", a), 32'(bus.mem_address), 32'(exp_blk));
        @(posedge clock);
      end
      @(negedge clock);
      chk("update_mem_read", 32'(bus.mem_read), 32'd0);
      chk("update_busywait", 32'(bus.busywait), 32'd1);
      @(posedge clock);
      model_valid[(int'(a) / 16) % NB] = 1'b1;
      model_tag[(int'(a) / 16) % NB]   = (int'(a) / 16) / NB;
      #1;
      @(negedge clock);
    end
    chk($sformatf("instr_at_%h", a), bus.instruction, exp_instr);
    @(posedge clock);
    #1;
  endtask

  logic [31:0] init_w [6];
  logic [31:0] v;

  initial begin
    init_w = '{32'h00060002, 32'h00070005, 32'h0A000603, 32'h0A000704,
               32'h03050607, 32'h0A00050F};
    for (int w = 0; w < 256; w++) begin
      v = (w < 6) ? init_w[w] : {16'hC0DE, 6'b0, 10'(w * 4)};
      for (int k = 0; k < 4; k++) mem[w*4 + k] = v[8*k +: 8];
    end
    for (int i = 0; i < NB; i++) begin
      model_valid[i] = 1'b0;
      model_tag[i]   = 0;
    end

    // Reset state with a would-be miss presented.
    bus.read = 1'b1;
    bus.pc   = 10'h000;
    #1;
    chk("reset_busywait",    32'(bus.busywait),    32'd0);
    chk("reset_mem_read",    32'(bus.mem_read),    32'd0);
    chk("reset_mem_address", 32'(bus.mem_address), 32'd0);
    chk("reset_instruction", bus.instruction,      32'h0);
    bus.read = 1'b0;
    #12 reset = 1'b1;
    @(posedge clock);
    #1;

    // Cold miss, hit in same line, second line miss, retry of the first line.
    fetch(10'h000, 1'b1, 32'h00060002, 6'd0);
    fetch(10'h004, 1'b0, 32'h00070005, 6'd0);
    fetch(10'h010, 1'b1, 32'h03050607, 6'd1);
    fetch(10'h000, 1'b0, 32'h00060002, 6'd0);
`ifdef ICACHE_STATS_EN
    chk("miss_count", 32'(miss_count), 32'd2);
    chk("hit_count",  32'(hit_count),  32'd4);
`endif
    fetch(10'h008, 1'b0, 32'h0A000603, 6'd0);
    fetch(10'h00C, 1'b0, 32'h0A000704, 6'd0);
    fetch(10'h014, 1'b0, 32'h0A00050F, 6'd1);

    // read low: no stall and no fill even at an uncached address.
    bus.read = 1'b0;
    bus.pc   = 10'h200;
    repeat (2) begin
      @(negedge clock);
      chk("idle_busywait", 32'(bus.busywait), 32'd0);
      chk("idle_mem_read", 32'(bus.mem_read), 32'd0);
    end
    @(posedge clock);
    #1;
    fetch(10'h200, 1'b1, 32'hC0DE0200, 6'd32);

    // Conflicts on index 0, top-of-memory line, untouched index 1 still hits.
    fetch(10'h080, 1'b1, 32'hC0DE0080, 6'd8);
    fetch(10'h000, 1'b1, 32'h00060002, 6'd0);
    fetch(10'h080, 1'b1, 32'hC0DE0080, 6'd8);
    fetch(10'h3FC, 1'b1, 32'hC0DE03FC, 6'd63);
    fetch(10'h3F0, 1'b0, 32'hC0DE03F0, 6'd63);
    fetch(10'h014, 1'b0, 32'h0A00050F, 6'd1);

    // Reset pulse in the middle of a block fetch.
    bus.pc   = 10'h040;
    bus.read = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("pre_reset_mem_read", 32'(bus.mem_read), 32'd1);
    #2 reset = 1'b0;
    for (int i = 0; i < NB; i++) model_valid[i] = 1'b0;
    #1;
    chk("async_reset_mem_read", 32'(bus.mem_read), 32'd0);
    chk("async_reset_busywait", 32'(bus.busywait), 32'd0);
    chk("async_reset_mem_address", 32'(bus.mem_address), 32'd0);
`ifdef ICACHE_STATS_EN
    chk("reset_miss_count", 32'(miss_count), 32'd0);
    chk("reset_hit_count",  32'(hit_count),  32'd0);
`endif
    bus.read = 1'b0;
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    #1;
    fetch(10'h040, 1'b1, 32'hC0DE0040, 6'd4);
    fetch(10'h014, 1'b1, 32'h0A00050F, 6'd1);
    fetch(10'h044, 1'b0, 32'hC0DE0044, 6'd4);

    bus.read = 1'b0;
    repeat (2) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/icache_direct.md
Name: icache_direct
Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch stage and the 1024x8 block-organised instruction memory. That memory has 16-byte blocks, a 6-bit block address, 128-bit readdata and a level-sensitive read/busywait handshake.
- Serves 32-bit instructions to the CPU on a hit with no stall.
- On a miss, stalls the CPU, fetches the whole 16-byte block, installs it, then serves the instruction.
Parameters:
- NUM_BLOCKS, 8, number of cache lines; power of 2, range 2..32. INDEX_W = log2(NUM_BLOCKS); TAG_W = 6 - INDEX_W.
- HIT_DELAY, 1, simulation-only delay in ns on the tag compare and word select; no effect on cycle behaviour.
Ports:
- clock  in  1  system clock, rising edge active.
- reset  in  1  asynchronous, active-low reset; 0 = reset.
- read  in  1  CPU fetch request.
- pc  in  10  byte address. [1:0] ignored, [3:2] word offset, [3+INDEX_W:4] index, [9:4+INDEX_W] tag.
- instruction  out  32  fetched instruction; valid when read=1 and busywait=0.
- busywait  out  1  CPU stall.
- mem_read  out  1  read request to instruction memory.
- mem_address  out  6  block address to instruction memory.
- mem_readdata  in  128  block from memory; byte k of the block is at bits [8k+7:8k].
- mem_busywait  in  1  memory busy; rises combinationally with mem_read, falls when the block is valid.
Behaviour:
- Storage: per line, valid bit, TAG_W tag and 128-bit data. Word w = data[32w+31:32w].
- hit = valid[idx] && tag[idx]==pc_tag, combinational.
- instruction = selected word when hit, else 32'h0.
- Reset asserted (async, not waiting for clock):
  - all valid bits 0; state IDLE.
  - mem_read 0, mem_address 0, busywait 0, miss-address latch 0.
  - Data and tag arrays are not cleared.
- FSM has three states: IDLE, MEM_READ, UPDATE.
- IDLE:
  - busywait = read && !hit.
  - On a clock edge with read && !hit: latch pc[9:4] into miss_addr, go to MEM_READ.
  - Otherwise stay in IDLE.
- MEM_READ:
  - mem_read=1, mem_address=miss_addr, busywait=1.
  - Go to UPDATE on the first clock edge where mem_busywait=0, provided at least one cycle has elapsed in this state (this guards against the combinational rise of mem_busywait).
  - Otherwise stay in MEM_READ.
- UPDATE:
  - mem_read=0, busywait=1.
  - On the clock edge, line[miss_addr index] gets data=mem_readdata, tag=miss_addr tag, valid=1.
  - Go to IDLE.
- Latency:
  - Hit: 0 stall cycles; the instruction is valid in the same cycle.
  - Miss: busywait covers the IDLE detect cycle + MEM_READ cycles + 1 UPDATE cycle. After that, IDLE re-evaluates and hits.
- pc is expected stable while busywait=1. If pc changes during a miss, the fill still uses miss_addr. After UPDATE, IDLE compares against the current pc, so the new pc may miss again. This is correct, not an error.
- read=0 in IDLE: busywait=0, no state change. read dropping during MEM_READ/UPDATE does not abort the fill.
- Conflict: a different tag at an occupied index overwrites that line. There is no write-back, because the cache is read-only.
- Reset during MEM_READ: mem_read drops immediately; the late memory response is ignored; the line is not installed.
- Consecutive misses to the same index reuse the same path; no bypass of mem_readdata to instruction.
Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined: adds outputs hit_count[15:0] and miss_count[15:0], both saturating at 16'hFFFF, cleared by reset.
  - hit_count increments on each clock edge in IDLE with read && hit. The post-fill retry counts as a hit.
  - miss_count increments on each IDLE->MEM_READ transition.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.
Test Plan:
- Cold miss at pc=0x000, memory preloaded with word0=32'h00060002:
  - busywait=1, mem_read=1, mem_address=6'd0 until mem_busywait falls.
  - One UPDATE cycle.
  - Then instruction=32'h00060002, busywait=0.
- After that fill, pc=0x004, 0x008, 0x00C: each returns its word (e.g. 0x00070005, 0x0A000603, 0x0A000704) with busywait never asserted and mem_read never asserted.
- pc=0x010: miss with mem_address=6'd1, then instruction=32'h03050607. pc=0x014 then hits with 32'h0A00050F.
- Conflict with NUM_BLOCKS=8:
  - Fill pc=0x000, then pc=0x080 misses (mem_address=6'd8) and evicts index 0.
  - pc=0x000 misses again (mem_address=6'd0).
- Reset pulse (reset=0) mid-MEM_READ:
  - mem_read and busywait go 0 asynchronously; state IDLE.
  - After release, pc=0x000 misses again; no line was installed.
- With ICACHE_STATS_EN, run the sequence 0x000, 0x004, 0x010, 0x000: miss_count=2, hit_count=4 (two post-fill retries plus 0x004 and the second 0x000).
